// File: rtl/lxcache_mem_arbiter.sv
// Round-robin arbiter giving NUM_PORTS Lxcache requesters shared access to one
// memory port. A single transaction is in flight at a time: IDLE picks a port,
// GRANT forwards its request until memory answers, RESP forwards the answer
// until the requester drops its message. Request and response paths are pure
// muxes steered by the registered grant.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-low reset
//   cache2mem_msg/address/data   packed per-port requests (port p at slice p)
//   mem2cache_msg/address/data   packed per-port responses
//   arb2mem_msg/address/data     request forwarded to the shared memory
//   mem2arb_msg/address/data     response from the shared memory
//   grant                        one-hot registered grant, 0 when idle
//   busy                         high while a transaction is in flight
module lxcache_mem_arbiter #(
  parameter int unsigned          NUM_PORTS         = 2,
  parameter int unsigned          MSG_BITS          = 4,
  parameter int unsigned          ADDRESS_BITS      = 32,
  parameter int unsigned          DATA_WIDTH        = 32,
  parameter int unsigned          CACHE_OFFSET_BITS = 2,
  parameter logic [MSG_BITS-1:0]  NO_REQ            = '0,
  localparam int unsigned         CACHE_WIDTH       = DATA_WIDTH << CACHE_OFFSET_BITS
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_PORTS*MSG_BITS-1:0]     cache2mem_msg,
  input  logic [NUM_PORTS*ADDRESS_BITS-1:0] cache2mem_address,
  input  logic [NUM_PORTS*CACHE_WIDTH-1:0]  cache2mem_data,
  output logic [NUM_PORTS*MSG_BITS-1:0]     mem2cache_msg,
  output logic [NUM_PORTS*ADDRESS_BITS-1:0] mem2cache_address,
  output logic [NUM_PORTS*CACHE_WIDTH-1:0]  mem2cache_data,
  output logic [MSG_BITS-1:0]               arb2mem_msg,
  output logic [ADDRESS_BITS-1:0]           arb2mem_address,
  output logic [CACHE_WIDTH-1:0]            arb2mem_data,
  input  logic [MSG_BITS-1:0]               mem2arb_msg,
  input  logic [ADDRESS_BITS-1:0]           mem2arb_address,
  input  logic [CACHE_WIDTH-1:0]            mem2arb_data,
  output logic [NUM_PORTS-1:0]              grant,
  output logic                              busy
);

  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e                  state_q;
  logic [NUM_PORTS-1:0]    grant_q;
  logic [PTR_W-1:0]        last_grant_q;

  logic [MSG_BITS-1:0]     port_msg  [NUM_PORTS];
  logic [ADDRESS_BITS-1:0] port_addr [NUM_PORTS];
  logic [CACHE_WIDTH-1:0]  port_data [NUM_PORTS];
  logic [NUM_PORTS-1:0]    req;
  logic [PTR_W-1:0]        cand;
  logic [PTR_W-1:0]        sel_idx;
  logic                    sel_valid;
  logic                    gnt_dropped;

  // Unpack the per-port request buses and derive the request vector.
  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      port_msg[p]  = cache2mem_msg[p*MSG_BITS +: MSG_BITS];
      port_addr[p] = cache2mem_address[p*ADDRESS_BITS +: ADDRESS_BITS];
      port_data[p] = cache2mem_data[p*CACHE_WIDTH +: CACHE_WIDTH];
      req[p]       = (port_msg[p] != NO_REQ);
    end
  end

  // Round-robin pick: scan offsets N..1 from the last winner so the smallest
  // offset that requests is the one left in sel_idx.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = last_grant_q;
    cand      = last_grant_q;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cand = PTR_W'((32'(last_grant_q) + (NUM_PORTS - k)) % NUM_PORTS);
      if (req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // While busy, last_grant_q always names the port holding the grant.
  assign gnt_dropped = (port_msg[last_grant_q] == NO_REQ);

  // Arbitration FSM with registered grant and round-robin pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= PTR_W'(NUM_PORTS - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_valid) begin
            state_q      <= GRANT;
            grant_q      <= NUM_PORTS'(1) << sel_idx;
            last_grant_q <= sel_idx;
          end
        end
        GRANT: begin
          if (mem2arb_msg != NO_REQ) begin
            state_q <= RESP;
          end else if (gnt_dropped) begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
        RESP: begin
          if (gnt_dropped) begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign busy  = (state_q != IDLE);
  assign grant = grant_q;

  // Forward the granted port's request to memory.
  always_comb begin
    arb2mem_msg     = NO_REQ;
    arb2mem_address = '0;
    arb2mem_data    = '0;
    if (busy) begin
      arb2mem_msg     = port_msg[last_grant_q];
      arb2mem_address = port_addr[last_grant_q];
      arb2mem_data    = port_data[last_grant_q];
    end
  end

  // Route the memory response back to the granted port only.
  always_comb begin
    mem2cache_msg     = '0;
    mem2cache_address = '0;
    mem2cache_data    = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      mem2cache_msg[p*MSG_BITS +: MSG_BITS] = NO_REQ;
      if (busy && grant_q[p]) begin
        mem2cache_msg[p*MSG_BITS +: MSG_BITS]             = mem2arb_msg;
        mem2cache_address[p*ADDRESS_BITS +: ADDRESS_BITS] = mem2arb_address;
        mem2cache_data[p*CACHE_WIDTH +: CACHE_WIDTH]      = mem2arb_data;
      end
    end
  end

endmodule

// File: tb/tb_lxcache_mem_arbiter.sv
// Scoreboard bench for lxcache_mem_arbiter with four ports: the stimulus
// process predicts each grant and response from a round-robin model and queues
// them; a negedge monitor pops and compares whenever the DUT presents them.
module tb_lxcache_mem_arbiter;

  localparam int NP  = 4;
  localparam int MB  = 4;
  localparam int AB  = 32;
  localparam int DW  = 32;
  localparam int COB = 2;
  localparam int CW  = DW << COB;

  typedef struct packed {
    logic [7:0]    port;
    logic [MB-1:0] msg;
    logic [AB-1:0] addr;
    logic [CW-1:0] data;
  } xact_t;

  logic              clock = 1'b0;
  logic              reset;
  logic [NP*MB-1:0]  c2m_msg;
  logic [NP*AB-1:0]  c2m_addr;
  logic [NP*CW-1:0]  c2m_data;
  logic [NP*MB-1:0]  m2c_msg;
  logic [NP*AB-1:0]  m2c_addr;
  logic [NP*CW-1:0]  m2c_data;
  logic [MB-1:0]     a2m_msg;
  logic [AB-1:0]     a2m_addr;
  logic [CW-1:0]     a2m_data;
  logic [MB-1:0]     m2a_msg;
  logic [AB-1:0]     m2a_addr;
  logic [CW-1:0]     m2a_data;
  logic [NP-1:0]     grant;
  logic              busy;

  lxcache_mem_arbiter #(
    .NUM_PORTS(NP), .MSG_BITS(MB), .ADDRESS_BITS(AB), .DATA_WIDTH(DW),
    .CACHE_OFFSET_BITS(COB), .NO_REQ(4'd0)
  ) dut (
    .clock(clock), .reset(reset),
    .cache2mem_msg(c2m_msg), .cache2mem_address(c2m_addr), .cache2mem_data(c2m_data),
    .mem2cache_msg(m2c_msg), .mem2cache_address(m2c_addr), .mem2cache_data(m2c_data),
    .arb2mem_msg(a2m_msg), .arb2mem_address(a2m_addr), .arb2mem_data(a2m_data),
    .mem2arb_msg(m2a_msg), .mem2arb_address(m2a_addr), .mem2arb_data(m2a_data),
    .grant(grant), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  xact_t exp_g[$];
  xact_t exp_r[$];

  // Behavioural model state: what each port currently presents, plus the last winner.
  bit            req_on [NP];
  logic [MB-1:0] m_msg  [NP];
  logic [AB-1:0] m_addr [NP];
  logic [CW-1:0] m_data [NP];
  int            last_m;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int winner();
    for (int i = 1; i <= NP; i++) begin
      int p;
      p = (last_m + i) % NP;
      if (req_on[p]) return p;
    end
    return -1;
  endfunction

  function automatic logic [CW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [MB-1:0] rnd_msg();
    return MB'($urandom_range(1, 15));
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_ports();
    for (int p = 0; p < NP; p++) begin
      c2m_msg[p*MB +: MB]  = req_on[p] ? m_msg[p] : '0;
      c2m_addr[p*AB +: AB] = req_on[p] ? m_addr[p] : '0;
      c2m_data[p*CW +: CW] = req_on[p] ? m_data[p] : '0;
    end
  endtask

  task automatic set_req(input int p, input logic [MB-1:0] msg, input logic [AB-1:0] addr,
                         input logic [CW-1:0] data);
    req_on[p] = 1'b1;
    m_msg[p]  = msg;
    m_addr[p] = addr;
    m_data[p] = data;
  endtask

  // One arbitration round starting in IDLE: grant, then abort, reset, or response and release.
  task automatic run_txn(input bit abort, input bit rst_mid, input bit extra,
                         input logic [MB-1:0] rmsg, input logic [AB-1:0] raddr,
                         input logic [CW-1:0] rdata);
    int w;
    xact_t x;
    w = winner();
    if (w < 0) begin
      drive_ports();
      tick();
      return;
    end
    x.port = 8'(w); x.msg = m_msg[w]; x.addr = m_addr[w]; x.data = m_data[w];
    exp_g.push_back(x);
    last_m = w;
    drive_ports();
    tick();                                  // now GRANT
    @(negedge clock); #1;
    if (extra) begin
      int p;
      p = $urandom_range(0, NP - 1);
      if (p != w) set_req(p, rnd_msg(), $urandom, rnd_data());
      drive_ports();
    end
    if (abort) begin
      req_on[w] = 1'b0;
      drive_ports();
      tick();                                // back to IDLE
      return;
    end
    x.port = 8'(w); x.msg = rmsg; x.addr = raddr; x.data = rdata;
    exp_r.push_back(x);
    m2a_msg = rmsg; m2a_addr = raddr; m2a_data = rdata;
    tick();                                  // now RESP
    @(negedge clock); #1;
    if (rst_mid) begin
      reset = 1'b0;
      #1;
      check("rst_mid_grant_busy", 512'({grant, busy}), 512'(0));
      check("rst_mid_arb2mem", 512'({a2m_msg, a2m_addr, a2m_data}), 512'(0));
      check("rst_mid_m2c_msg_addr", 512'({m2c_msg, m2c_addr}), 512'(0));
      check("rst_mid_m2c_data", 512'(m2c_data), 512'(0));
      m2a_msg = '0; m2a_addr = '0; m2a_data = '0;
      for (int p = 0; p < NP; p++) req_on[p] = 1'b0;
      drive_ports();
      #1 reset = 1'b1;
      last_m = NP - 1;
      tick();
      return;
    end
    m2a_msg = '0; m2a_addr = '0; m2a_data = '0;
    req_on[w] = 1'b0;
    drive_ports();
    tick();                                  // back to IDLE
  endtask

  // Monitor: pops expectations when the DUT presents a new grant or a response.
  logic [NP-1:0] prev_grant = '0;
  xact_t         active;
  bit            active_ok = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      if (grant != '0 && prev_grant == '0) begin
        if (exp_g.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL grant_unexpected: got grant %b with nothing expected", grant);
          active_ok = 1'b0;
        end else begin
          active    = exp_g.pop_front();
          active_ok = 1'b1;
        end
      end
      if (grant != '0) begin
        if (active_ok) begin
          logic [NP-1:0] eg;
          eg = '0;
          eg[active.port] = 1'b1;
          check("grant_onehot", 512'({grant, busy}), 512'({eg, 1'b1}));
          check("arb2mem_fwd", 512'({a2m_msg, a2m_addr, a2m_data}),
                512'({active.msg, active.addr, active.data}));
        end
        if (m2c_msg != '0) begin
          if (exp_r.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL resp_unexpected: got m2c_msg %h with nothing expected", m2c_msg);
          end else begin
            xact_t r;
            logic [NP*MB-1:0] em;
            logic [NP*AB-1:0] ea;
            logic [NP*CW-1:0] ed;
            r  = exp_r.pop_front();
            em = '0; ea = '0; ed = '0;
            em[r.port*MB +: MB] = r.msg;
            ea[r.port*AB +: AB] = r.addr;
            ed[r.port*CW +: CW] = r.data;
            check("resp_msg_addr", 512'({m2c_msg, m2c_addr}), 512'({em, ea}));
            check("resp_data", 512'(m2c_data), 512'(ed));
          end
        end else begin
          check("no_resp_yet", 512'({m2c_addr}), 512'(0));
        end
      end else begin
        active_ok = 1'b0;
        check("idle_arb2mem_busy", 512'({busy, a2m_msg, a2m_addr, a2m_data}), 512'(0));
        check("idle_m2c", 512'({m2c_msg, m2c_addr}), 512'(0));
        check("idle_m2c_data", 512'(m2c_data), 512'(0));
      end
    end
    prev_grant = grant;
  end

  initial begin
    for (int p = 0; p < NP; p++) begin
      req_on[p] = 1'b0; m_msg[p] = '0; m_addr[p] = '0; m_data[p] = '0;
    end
    last_m = NP - 1;
    m2a_msg = '0; m2a_addr = '0; m2a_data = '0;
    drive_ports();
    reset = 1'b0;
    #3;
    check("reset_grant_busy", 512'({grant, busy}), 512'(0));
    check("reset_arb2mem", 512'({a2m_msg, a2m_addr, a2m_data}), 512'(0));
    check("reset_m2c", 512'({m2c_msg, m2c_addr}), 512'(0));
    #9 reset = 1'b1;
    tick();

    // Simultaneous requests from reset: port 0 first, then port 1 after a bubble.
    set_req(0, 4'd1, 32'h100, rnd_data());
    set_req(1, 4'd1, 32'h200, rnd_data());
    run_txn(0, 0, 0, 4'd2, 32'h100, rnd_data());
    run_txn(0, 0, 0, 4'd3, 32'h200, {4{32'hDEADBEEF}});

    // Port 0 re-requests after every service; port 1 must still get its turn.
    set_req(0, 4'd1, 32'h300, rnd_data());
    set_req(1, 4'd1, 32'h400, rnd_data());
    run_txn(0, 0, 0, 4'd5, 32'h300, rnd_data());
    set_req(0, 4'd1, 32'h304, rnd_data());
    run_txn(0, 0, 0, 4'd5, 32'h400, rnd_data());
    run_txn(0, 0, 0, 4'd5, 32'h304, rnd_data());

    // Abort in GRANT before memory answers.
    set_req(2, 4'd2, 32'h500, rnd_data());
    run_txn(1, 0, 0, 4'd0, 32'h0, '0);

    // With last winner 1, ports 1 and 3 requesting: port 3 wins.
    set_req(1, 4'd1, 32'h600, rnd_data());
    run_txn(0, 0, 0, 4'd6, 32'h600, rnd_data());
    set_req(1, 4'd1, 32'h610, rnd_data());
    set_req(3, 4'd1, 32'h630, rnd_data());
    run_txn(0, 0, 0, 4'd7, 32'h630, rnd_data());
    run_txn(0, 0, 0, 4'd7, 32'h610, rnd_data());

    // Reset during RESP, then port 0 wins first again.
    set_req(2, 4'd4, 32'h700, rnd_data());
    run_txn(0, 1, 0, 4'd8, 32'h700, rnd_data());
    set_req(0, 4'd1, 32'h800, rnd_data());
    set_req(3, 4'd1, 32'h830, rnd_data());
    run_txn(0, 0, 0, 4'd9, 32'h800, rnd_data());
    run_txn(0, 0, 0, 4'd9, 32'h830, rnd_data());

    // Randomized traffic with aborts, late requests on other ports, and mid-flight resets.
    for (int it = 0; it < 300; it++) begin
      for (int p = 0; p < NP; p++) begin
        if (!req_on[p] && $urandom_range(0, 99) < 35) set_req(p, rnd_msg(), $urandom, rnd_data());
      end
      run_txn($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 30,
              rnd_msg(), $urandom, rnd_data());
    end

    for (int p = 0; p < NP; p++) req_on[p] = 1'b0;
    drive_ports();
    tick();
    tick();
    check("grants_all_seen", 512'(exp_g.size()), 512'(0));
    check("resps_all_seen", 512'(exp_r.size()), 512'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
